flood_fill: RTL and testbench

Connected-component fill engine for the labelling pipeline. It sits directly upstream of the LIFO `stack`: it owns the stack's push/pop port and uses it as its coordinate work-list. Given a seed pixel and a label, it writes that label into every 4-connected, unlabelled foreground pixel reachable from the seed. It reports the component's area and bounding box.

---
 rtl/flood_fill.sv | 233 +++++++++++++++++++++++
 tb/tb_flood_fill.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flood_fill.sv
// Connected-component fill engine: labels every 4-connected, unlabelled foreground
// pixel reachable from a seed, using an external LIFO stack as its work-list.
module flood_fill #(
    parameter int X_WIDTH     = 8,
    parameter int Y_WIDTH     = 8,
    parameter int IMG_W       = 256,
    parameter int IMG_H       = 256,
    parameter int LABEL_WIDTH = 8,
    parameter int AREA_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [X_WIDTH-1:0]         seed_x,
    input  logic [Y_WIDTH-1:0]         seed_y,
    input  logic [LABEL_WIDTH-1:0]     label,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [AREA_WIDTH-1:0]      area,
    output logic [X_WIDTH-1:0]         min_x,
    output logic [X_WIDTH-1:0]         max_x,
    output logic [Y_WIDTH-1:0]         min_y,
    output logic [Y_WIDTH-1:0]         max_y,
    output logic [X_WIDTH+Y_WIDTH-1:0] img_raddr,
    input  logic                       img_fg,
    input  logic [LABEL_WIDTH-1:0]     img_lbl,
    output logic                       lbl_wen,
    output logic [X_WIDTH+Y_WIDTH-1:0] lbl_waddr,
    output logic [LABEL_WIDTH-1:0]     lbl_wdata,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [X_WIDTH+Y_WIDTH-1:0] stk_din,
    input  logic [X_WIDTH+Y_WIDTH-1:0] stk_dout,
    input  logic                       stk_full,
    input  logic                       stk_empty
);

    localparam int                 A_WIDTH = X_WIDTH + Y_WIDTH;
    localparam logic [X_WIDTH-1:0] X_LAST  = X_WIDTH'(IMG_W - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST  = Y_WIDTH'(IMG_H - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEED_RD,
        S_SEED_CHK,
        S_WAIT,
        S_POP,
        S_NBR_RD,
        S_NBR_CHK,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state;
    logic [X_WIDTH-1:0]     cur_x;
    logic [Y_WIDTH-1:0]     cur_y;
    logic [1:0]             nbr;
    logic [LABEL_WIDTH-1:0] fill_label;

    logic [X_WIDTH-1:0]     nbr_x;
    logic [Y_WIDTH-1:0]     nbr_y;
    logic                   nbr_inb;
    logic                   qualify;
    logic                   write_seed;
    logic                   write_nbr;
    logic                   last_nbr;
    logic [A_WIDTH-1:0]     wr_addr;

    // Neighbour order is left, right, up, down; the edge test uses the current pixel.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        nbr_x   = cur_x;
        nbr_y   = cur_y;
        nbr_inb = 1'b0;
        case (nbr)
            2'd0: begin
                nbr_x   = cur_x - X_WIDTH'(1);
                nbr_inb = (cur_x != '0);
            end
            2'd1: begin
                nbr_x   = cur_x + X_WIDTH'(1);
                nbr_inb = (cur_x != X_LAST);
            end
            2'd2: begin
                nbr_y   = cur_y - Y_WIDTH'(1);
                nbr_inb = (cur_y != '0);
            end
            default: begin
                nbr_y   = cur_y + Y_WIDTH'(1);
                nbr_inb = (cur_y != Y_LAST);
            end
        endcase
    end

    assign qualify    = img_fg && (img_lbl == '0);
    assign write_seed = (state == S_SEED_CHK) && qualify;
    assign write_nbr  = (state == S_NBR_CHK) && qualify && !stk_full;
    assign last_nbr   = (nbr == 2'd3);

    // Strobes react to read data in the same cycle, so labelling and pushing coincide.
    always_comb begin
        img_raddr = '0;
        if (state == S_SEED_RD) begin
            img_raddr = {cur_y, cur_x};
        end else if ((state == S_NBR_RD) && nbr_inb) begin
            img_raddr = {nbr_y, nbr_x};
        end

        wr_addr = '0;
        if (write_seed) begin
            wr_addr = {cur_y, cur_x};
        end else if (write_nbr) begin
            wr_addr = {nbr_y, nbr_x};
        end

        lbl_wen   = write_seed || write_nbr;
        stk_push  = write_seed || write_nbr;
        lbl_waddr = wr_addr;
        stk_din   = wr_addr;
        lbl_wdata = (write_seed || write_nbr) ? fill_label : '0;
        stk_pop   = (state == S_POP) || ((state == S_DRAIN) && !stk_empty);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            nbr        <= '0;
            fill_label <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            area       <= '0;
            min_x      <= '0;
            max_x      <= '0;
            min_y      <= '0;
            max_y      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_x      <= seed_x;
                        cur_y      <= seed_y;
                        fill_label <= label;
                        min_x      <= seed_x;
                        max_x      <= seed_x;
                        min_y      <= seed_y;
                        max_y      <= seed_y;
                        area       <= '0;
                        overflow   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_SEED_RD;
                    end
                end

                S_SEED_RD: state <= S_SEED_CHK;

                S_SEED_CHK: begin
                    if (qualify) begin
                        area  <= AREA_WIDTH'(1);
                        state <= S_WAIT;
                    end else begin
                        state <= S_DONE;
                    end
                end

                // One idle cycle lets the registered top-of-stack catch up.
                S_WAIT: state <= stk_empty ? S_DONE : S_POP;

                S_POP: begin
                    cur_x <= stk_dout[X_WIDTH-1:0];
                    cur_y <= stk_dout[A_WIDTH-1:X_WIDTH];
                    nbr   <= 2'd0;
                    state <= S_NBR_RD;
                end

                S_NBR_RD: begin
                    if (nbr_inb) begin
                        state <= S_NBR_CHK;
                    end else if (last_nbr) begin
                        state <= S_WAIT;
                    end else begin
                        nbr <= nbr + 2'd1;
                    end
                end

                S_NBR_CHK: begin
                    if (qualify && stk_full) begin
                        overflow <= 1'b1;
                        state    <= S_DRAIN;
                    end else begin
                        if (qualify) begin
                            if (area != '1) begin
                                area <= area + AREA_WIDTH'(1);
                            end
                            if (nbr_x < min_x) min_x <= nbr_x;
                            if (nbr_x > max_x) max_x <= nbr_x;
                            if (nbr_y < min_y) min_y <= nbr_y;
                            if (nbr_y > max_y) max_y <= nbr_y;
                        end
                        if (last_nbr) begin
                            state <= S_WAIT;
                        end else begin
                            nbr   <= nbr + 2'd1;
                            state <= S_NBR_RD;
                        end
                    end
                end

                // Empty the stack so the next fill starts from a clean work-list.
                S_DRAIN: begin
                    if (stk_empty) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flood_fill.sv
// Self-checking bench for flood_fill: behavioural image memory and stack, plus a
// queue-based component model that predicts labels, area, bounding box and latency.
module tb_flood_fill;

    localparam int XW  = 5;
    localparam int YW  = 5;
    localparam int IW  = 20;
    localparam int IH  = 14;
    localparam int LW  = 8;
    localparam int ARW = 16;
    localparam int AW  = XW + YW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [XW-1:0] seed_x;
    logic [YW-1:0] seed_y;
    logic [LW-1:0] label;
    logic          busy, done, overflow;
    logic [ARW-1:0] area;
    logic [XW-1:0] min_x, max_x;
    logic [YW-1:0] min_y, max_y;
    logic [AW-1:0] img_raddr;
    logic          img_fg;
    logic [LW-1:0] img_lbl;
    logic          lbl_wen;
    logic [AW-1:0] lbl_waddr;
    logic [LW-1:0] lbl_wdata;
    logic          stk_push, stk_pop;
    logic [AW-1:0] stk_din, stk_dout;
    logic          stk_full, stk_empty;

    flood_fill #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .IMG_W(IW), .IMG_H(IH),
        .LABEL_WIDTH(LW), .AREA_WIDTH(ARW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .seed_x(seed_x), .seed_y(seed_y), .label(label),
        .busy(busy), .done(done), .overflow(overflow), .area(area),
        .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
        .img_raddr(img_raddr), .img_fg(img_fg), .img_lbl(img_lbl),
        .lbl_wen(lbl_wen), .lbl_waddr(lbl_waddr), .lbl_wdata(lbl_wdata),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    // Image memory: synchronous read, label write port, and a loader port.
    logic          mem_fg  [0:(1<<AW)-1];
    logic [LW-1:0] mem_lbl [0:(1<<AW)-1];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic          ld_fg;
    logic [LW-1:0] ld_lbl;

    always @(posedge clk) begin
        if (ld_en) begin
            mem_fg[ld_addr]  <= ld_fg;
            mem_lbl[ld_addr] <= ld_lbl;
        end else if (lbl_wen) begin
            mem_lbl[lbl_waddr] <= lbl_wdata;
        end
        img_fg  <= mem_fg[img_raddr];
        img_lbl <= mem_lbl[img_raddr];
    end

    // LIFO with a run-time capacity and a registered top-of-stack.
    logic [AW-1:0] stk_mem [0:1023];
    int            stk_cnt;
    int            stk_cap;

    assign stk_full  = (stk_cnt >= stk_cap);
    assign stk_empty = (stk_cnt == 0);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stk_cnt  <= 0;
            stk_dout <= '0;
        end else begin
            stk_dout <= (stk_cnt > 0) ? stk_mem[stk_cnt-1] : '0;
            if (stk_push && !stk_full) begin
                stk_mem[stk_cnt] <= stk_din;
                stk_cnt          <= stk_cnt + 1;
            end else if (stk_pop && !stk_empty) begin
                stk_cnt <= stk_cnt - 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int n_done   = 0;
    int cur_label = 0;

    int m_fg  [IH][IW];
    int m_lbl [IH][IW];

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint bbox_pack(input int x0, x1, y0, y1);
        return (longint'(x0) << 15) | (longint'(x1) << 10) | (longint'(y0) << 5) | longint'(y1);
    endfunction

    // Continuous protocol checks on strobes and write targets.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (stk_push || stk_pop) check("push_pop_excl", stk_push & stk_pop, 0);
            if (stk_push || lbl_wen) check("wen_eq_push", lbl_wen, stk_push);
            if (lbl_wen) begin
                n_writes++;
                check("waddr_eq_din", lbl_waddr, stk_din);
                check("wr_data", lbl_wdata, cur_label);
                check("wr_unlabelled", mem_lbl[lbl_waddr], 0);
                check("wr_fg", mem_fg[lbl_waddr], 1);
                check("wr_not_full", stk_full, 0);
            end
            if (busy) check("raddr_bounds", (img_raddr[XW-1:0] < IW) && (img_raddr[AW-1:XW] < IH), 1);
            if (done) n_done++;
        end
    endtask

    task automatic clear_image();
        foreach (m_fg[y, x]) begin
            m_fg[y][x]  = 0;
            m_lbl[y][x] = 0;
        end
    endtask

    task automatic full_image();
        foreach (m_fg[y, x]) begin
            m_fg[y][x]  = 1;
            m_lbl[y][x] = 0;
        end
    endtask

    task automatic random_image();
        foreach (m_fg[y, x]) begin
            m_fg[y][x]  = ($urandom_range(99) < 60) ? 1 : 0;
            m_lbl[y][x] = (m_fg[y][x] == 1 && $urandom_range(9) == 0) ? int'($urandom_range(3, 1)) : 0;
        end
    endtask

    task automatic load_image();
        for (int y = 0; y < IH; y++) begin
            for (int x = 0; x < IW; x++) begin
                @(negedge clk);
                ld_en   = 1'b1;
                ld_addr = AW'((y << XW) | x);
                ld_fg   = m_fg[y][x][0];
                ld_lbl  = LW'(m_lbl[y][x]);
            end
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Reference: breadth-first search over qualifying pixels; cost per labelled
    // pixel is 2 + 2 per in-bounds neighbour + 1 per out-of-bounds neighbour.
    task automatic model_fill(input int sx, sy, lab,
                              output int ea, ex0, ex1, ey0, ey1, ec);
        bit seen [IH][IW];
        int q[$];
        ea = 0; ex0 = sx; ex1 = sx; ey0 = sy; ey1 = sy;
        if (!(m_fg[sy][sx] == 1 && m_lbl[sy][sx] == 0)) begin
            ec = 3;
            return;
        end
        foreach (seen[i, j]) seen[i][j] = 1'b0;
        ec = 4;
        seen[sy][sx] = 1'b1;
        q.push_back(sy * IW + sx);
        while (q.size() > 0) begin
            int p, x, y, inb;
            p = q.pop_front();
            x = p % IW;
            y = p / IW;
            m_lbl[y][x] = lab;
            ea++;
            if (x < ex0) ex0 = x;
            if (x > ex1) ex1 = x;
            if (y < ey0) ey0 = y;
            if (y > ey1) ey1 = y;
            inb = 0;
            for (int d = 0; d < 4; d++) begin
                int nx, ny;
                nx = x;
                ny = y;
                case (d)
                    0: nx = x - 1;
                    1: nx = x + 1;
                    2: ny = y - 1;
                    default: ny = y + 1;
                endcase
                if (nx >= 0 && nx < IW && ny >= 0 && ny < IH) begin
                    inb++;
                    if (m_fg[ny][nx] == 1 && m_lbl[ny][nx] == 0 && !seen[ny][nx]) begin
                        seen[ny][nx] = 1'b1;
                        q.push_back(ny * IW + nx);
                    end
                end
            end
            ec += 6 + inb;
        end
    endtask

    task automatic run_fill(input int sx, sy, lab, input bit poke, output int cycles);
        @(negedge clk);
        seed_x    = XW'(sx);
        seed_y    = YW'(sy);
        label     = LW'(lab);
        cur_label = lab;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        forever begin
            @(posedge clk);
            #1;
            cycles++;
            if (poke && cycles == 4) begin
                start  = 1'b1;
                seed_x = '0;
                seed_y = '0;
                label  = 8'd99;
            end else begin
                start = 1'b0;
            end
            if (done) break;
            if (cycles >= 20000) begin
                check("done_seen", done, 1);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_labels(input string tag);
        int bad = 0;
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++)
                if (mem_lbl[(y << XW) | x] !== LW'(m_lbl[y][x])) bad++;
        check(tag, bad, 0);
    endtask

    task automatic fill_and_check(input int sx, sy, lab, input bit poke,
                                  input string tag, output int cyc);
        int ea, ex0, ex1, ey0, ey1, ec;
        model_fill(sx, sy, lab, ea, ex0, ex1, ey0, ey1, ec);
        run_fill(sx, sy, lab, poke, cyc);
        check({tag, "_latency"}, cyc, ec);
        check({tag, "_area"}, area, ea);
        check({tag, "_bbox"}, {min_x, max_x, min_y, max_y}, bbox_pack(ex0, ex1, ey0, ey1));
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_stk_empty"}, stk_empty, 1);
        check_labels({tag, "_labels"});
    endtask

    initial begin
        int cyc, w0, d0;
        reset_n = 1'b0; start = 1'b0; seed_x = '0; seed_y = '0; label = '0;
        ld_en = 1'b0; ld_addr = '0; ld_fg = 1'b0; ld_lbl = '0; stk_cap = 1023;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", {busy, done, overflow, lbl_wen, stk_push, stk_pop}, 0);
        check("rst_area", area, 0);
        check("rst_bbox", {min_x, max_x, min_y, max_y}, 0);
        check("rst_addrs", {img_raddr, lbl_waddr, stk_din, lbl_wdata}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Isolated interior seed.
        clear_image();
        m_fg[5][5] = 1;
        load_image();
        w0 = n_writes;
        fill_and_check(5, 5, 9, 1'b0, "iso", cyc);
        check("iso_latency14", cyc, 14);
        check("iso_writes", n_writes - w0, 1);

        // 3x3 block with a start pulse dropped mid-fill, plus rejected seeds.
        clear_image();
        for (int y = 10; y <= 12; y++)
            for (int x = 10; x <= 12; x++) m_fg[y][x] = 1;
        m_fg[2][15]  = 1;
        m_lbl[2][15] = 3;
        load_image();
        w0 = n_writes;
        fill_and_check(11, 11, 7, 1'b1, "block", cyc);
        check("block_writes", n_writes - w0, 9);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("drop_busy", busy, 0);
            check("drop_area_held", area, 9);
        end
        w0 = n_writes;
        fill_and_check(0, 0, 5, 1'b0, "seed_bg", cyc);
        check("seed_bg_latency3", cyc, 3);
        fill_and_check(15, 2, 5, 1'b0, "seed_lbl", cyc);
        check("seed_lbl_latency3", cyc, 3);
        check("reject_writes", n_writes - w0, 0);

        // Whole image foreground from the corner.
        full_image();
        load_image();
        fill_and_check(0, 0, 200, 1'b0, "full", cyc);
        check("full_area_abs", area, IW * IH);
        check("full_bbox_abs", {min_x, max_x, min_y, max_y}, bbox_pack(0, IW - 1, 0, IH - 1));

        // Capacity-3 stack: the seed's fourth neighbour cannot be pushed.
        full_image();
        load_image();
        stk_cap = 3;
        d0 = n_done;
        run_fill(5, 5, 33, 1'b0, cyc);
        check("ovf_flag", overflow, 1);
        check("ovf_area", area, 4);
        check("ovf_stk_empty", stk_empty, 1);
        m_lbl[5][5] = 33; m_lbl[5][4] = 33; m_lbl[5][6] = 33; m_lbl[4][5] = 33;
        check_labels("ovf_labels");
        repeat (5) @(posedge clk);
        #1;
        check("ovf_done_once", n_done - d0, 1);
        check("ovf_held", overflow, 1);
        stk_cap = 1023;

        // Asynchronous reset in the middle of a fill.
        full_image();
        load_image();
        @(negedge clk);
        seed_x = 5'd3; seed_y = 5'd3; label = 8'd44; cur_label = 44; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("arst_flags", {busy, done, overflow, lbl_wen, stk_push, stk_pop}, 0);
        check("arst_area", area, 0);
        check("arst_bbox", {min_x, max_x, min_y, max_y}, 0);
        check("arst_addrs", {img_raddr, lbl_waddr, stk_din, lbl_wdata}, 0);
        check("arst_stk_empty", stk_empty, 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        random_image();
        m_fg[6][6] = 1;
        m_lbl[6][6] = 0;
        load_image();
        fill_and_check(6, 6, 77, 1'b0, "post_rst", cyc);

        // Random images, two fills each so the second sees earlier labels.
        for (int t = 0; t < 8; t++) begin
            random_image();
            load_image();
            for (int k = 0; k < 2; k++) begin
                fill_and_check(int'($urandom_range(IW - 1)), int'($urandom_range(IH - 1)),
                               int'($urandom_range(255, 4)), 1'b0, "rand", cyc);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
